// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard and zeroing sweep FSM.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wn,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     clr,
   output logic                     clr_busy
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic [ADDR_W-1:0] idx;
   logic              idle;
   logic              start;
   logic              last;
   logic              wr_ok;
   logic              iss_ok;

   assign idle     = (state == IDLE);
   assign clr_busy = !idle;

   // A clr pulse in IDLE pre-empts any write or issue in that cycle
   assign wr_ok  = idle && !clr && we && (wn != '0);
   assign iss_ok = idle && !clr && iss_valid && (iss_addr != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      last      = 1'b0;
      unique case (state)
         IDLE: begin
            if (clr) begin
               state_nxt = CLEAR;
               start     = 1'b1;
            end
         end
         CLEAR: begin
            last = (idx == LAST);
            if (last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx <= '0;
      end else if (start) begin
         idx <= ADDR_W'(1);
      end else if (!idle) begin
         idx <= last ? '0 : idx + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (!idle) begin
         regs[idx] <= '0;
      end else if (wr_ok) begin
         regs[wn] <= wdata;
      end
   end

   // Set is applied last so a same-cycle issue outranks the retiring write
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending <= '0;
      end else if (start) begin
         pending <= '0;
      end else begin
         if (wr_ok) begin
            pending[wn] <= 1'b0;
         end
         if (iss_ok) begin
            pending[iss_addr] <= 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] q;
      assign a = rd_addr[k*ADDR_W +: ADDR_W];
      assign q = (a == '0) ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
      logic hit;
      assign hit = reset && we && idle && (wn == a) && (wn != '0);
      assign rd_data[k*DATA_W +: DATA_W] = hit ? wdata : q;
      assign rd_busy[k] = pending[a] && !hit;
`else
      assign rd_data[k*DATA_W +: DATA_W] = q;
      assign rd_busy[k] = pending[a];
`endif
   end

endmodule
